udma_ptp_ts_arb: RTL and testbench

- Round-robin arbiter and serializer that shares one 32-bit uDMA RX channel between NB_SRC 96-bit PTP timestamp sources, for example the RX-frame and TX-frame timestamp streams.
- Each accepted timestamp is emitted as one 4-word record: a header word followed by three timestamp words, most-significant word first.
- The block sits in the sys_clk_i domain, after the per-source clock-domain-crossing FIFOs and ahead of the channel's 32-bit element-counting FIFO.
- It also implements enable/drop policy and per-source sequence and drop counters for the register file.

---
 rtl/udma_ptp_ts_arb.sv | 187 ++++++++++++++++++
 tb/tb_udma_ptp_ts_arb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_ptp_ts_arb.sv
`default_nettype none
// ============================================================================
//  Module   : udma_ptp_ts_arb
//  Purpose  : Round-robin arbiter / serializer that shares one 32-bit uDMA RX
//             channel between NB_SRC 96-bit PTP timestamp sources. Each
//             accepted timestamp leaves as a 4-word record: header, then the
//             timestamp most-significant word first. Also applies the
//             enable/drop policy and keeps per-source sequence and drop
//             counters.
//  Ports    : sys_clk_i, rstn_i (async, active low)
//             en_i, clr_i            - register-file enable / sync clear
//             src_data_i/valid/ready - NB_SRC timestamp inputs (96 bits each)
//             data_o/valid_o/ready_i - 32-bit word stream to the RX FIFO
//             busy_o, grant_o        - record in flight / last granted source
//             drop_cnt_o             - per-source saturating drop counters
//  Revision : 1.0 - initial release
// ============================================================================
module udma_ptp_ts_arb #(
   parameter int NB_SRC     = 2,
   parameter int SEQ_WIDTH  = 16,
   parameter int DROP_WIDTH = 16
) (
   input  logic                         sys_clk_i,
   input  logic                         rstn_i,
   input  logic                         en_i,
   input  logic                         clr_i,
   input  logic [NB_SRC*96-1:0]         src_data_i,
   input  logic [NB_SRC-1:0]            src_valid_i,
   output logic [NB_SRC-1:0]            src_ready_o,
   output logic [31:0]                  data_o,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic                         busy_o,
   output logic [1:0]                   grant_o,
   output logic [NB_SRC*DROP_WIDTH-1:0] drop_cnt_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_W_HI  = 3'd2,
      ST_W_MID = 3'd3,
      ST_W_LO  = 3'd4
   } state_t;

   localparam logic [DROP_WIDTH-1:0] c_drop_max = '1;
   // "Last grant" at reset/clear points at the top source so source 0 wins first.
   localparam logic [1:0]            c_last_rst = 2'(NB_SRC-1);

   state_t                 r_state, w_state_nxt;
   logic [95:0]            r_buf;
   logic [1:0]             r_grant;
   logic [1:0]             r_last;
   logic [SEQ_WIDTH-1:0]   r_hdr_seq;
   logic [SEQ_WIDTH-1:0]   r_seq  [NB_SRC];
   logic [DROP_WIDTH-1:0]  r_drop [NB_SRC];

   logic                   w_idle;
   logic                   w_found;
   logic [1:0]             w_win;
   logic [NB_SRC-1:0]      w_ready;
   logic [31:0]            w_hdr;
   int                     w_dist;
   int                     w_best;

   assign w_idle = (r_state == ST_IDLE);
   assign w_hdr  = {4'hA, 2'b00, r_grant, 24'(r_hdr_seq)};

   // Round-robin pick: the valid source with the smallest circular distance
   // from (last grant + 1) wins. Constant loop indices keep every select static.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_best  = NB_SRC;
      w_dist  = 0;
      for (int i = 0; i < NB_SRC; i++) begin
         w_dist = i - int'(r_last) - 1;
         if (w_dist < 0) w_dist = w_dist + NB_SRC;
         if (src_valid_i[i] && (w_dist < w_best)) begin
            w_best  = w_dist;
            w_win   = 2'(i);
            w_found = 1'b1;
         end
      end
   end

   // Ready is combinational from valid; held low in reset so every output is
   // quiet while rstn_i is asserted. Disabled mode drains everything pending.
   always_comb begin
      w_ready = '0;
      if (rstn_i && w_idle && !clr_i) begin
         if (en_i) begin
            for (int i = 0; i < NB_SRC; i++)
               w_ready[i] = w_found && (w_win == 2'(i));
         end else begin
            w_ready = src_valid_i;
         end
      end
   end

   // FSM next state and word mux
   always_comb begin
      w_state_nxt = r_state;
      valid_o     = 1'b0;
      data_o      = '0;
      case (r_state)
         ST_IDLE: begin
            if (en_i && w_found) w_state_nxt = ST_HDR;
         end
         ST_HDR: begin
            valid_o = 1'b1;
            data_o  = w_hdr;
            if (ready_i) w_state_nxt = ST_W_HI;
         end
         ST_W_HI: begin
            valid_o = 1'b1;
            data_o  = r_buf[95:64];
            if (ready_i) w_state_nxt = ST_W_MID;
         end
         ST_W_MID: begin
            valid_o = 1'b1;
            data_o  = r_buf[63:32];
            if (ready_i) w_state_nxt = ST_W_LO;
         end
         ST_W_LO: begin
            valid_o = 1'b1;
            data_o  = r_buf[31:0];
            if (ready_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Clear aborts any in-flight record.
      if (clr_i) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_buf     <= '0;
         r_grant   <= '0;
         r_last    <= c_last_rst;
         r_hdr_seq <= '0;
         for (int i = 0; i < NB_SRC; i++) begin
            r_seq[i]  <= '0;
            r_drop[i] <= '0;
         end
      end else if (clr_i) begin
         r_grant <= '0;
         r_last  <= c_last_rst;
         for (int i = 0; i < NB_SRC; i++) begin
            r_seq[i]  <= '0;
            r_drop[i] <= '0;
         end
      end else if (w_idle && en_i && w_found) begin
         r_grant <= w_win;
         r_last  <= w_win;
         for (int i = 0; i < NB_SRC; i++) begin
            if (w_win == 2'(i)) begin
               r_buf     <= src_data_i[i*96 +: 96];
               r_hdr_seq <= r_seq[i];
               r_seq[i]  <= r_seq[i] + 1'b1;
            end
         end
      end else if (w_idle && !en_i) begin
         for (int i = 0; i < NB_SRC; i++) begin
            if (src_valid_i[i] && (r_drop[i] != c_drop_max))
               r_drop[i] <= r_drop[i] + 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < NB_SRC; g++) begin : g_drop
         assign drop_cnt_o[g*DROP_WIDTH +: DROP_WIDTH] = r_drop[g];
      end
   endgenerate

   assign src_ready_o = w_ready;
   assign busy_o      = !w_idle;
   assign grant_o     = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_udma_ptp_ts_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udma_ptp_ts_arb
//  Purpose  : Scoreboard bench for udma_ptp_ts_arb. Directed stimulus pushes
//             the hand-computed word stream into a queue; a monitor pops and
//             compares on every output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_udma_ptp_ts_arb;
   localparam int NB_SRC = 2;
   localparam int SEQ_W  = 4;
   localparam int DROP_W = 8;

   logic                     sys_clk_i = 1'b0;
   logic                     rstn_i    = 1'b0;
   logic                     en_i      = 1'b0;
   logic                     clr_i     = 1'b0;
   logic [NB_SRC*96-1:0]     src_data_i  = '0;
   logic [NB_SRC-1:0]        src_valid_i = '0;
   logic                     ready_i   = 1'b0;
   logic [NB_SRC-1:0]        src_ready_o;
   logic [31:0]              data_o;
   logic                     valid_o;
   logic                     busy_o;
   logic [1:0]               grant_o;
   logic [NB_SRC*DROP_W-1:0] drop_cnt_o;

   udma_ptp_ts_arb #(.NB_SRC(NB_SRC), .SEQ_WIDTH(SEQ_W), .DROP_WIDTH(DROP_W)) dut (
      .sys_clk_i  (sys_clk_i),
      .rstn_i     (rstn_i),
      .en_i       (en_i),
      .clr_i      (clr_i),
      .src_data_i (src_data_i),
      .src_valid_i(src_valid_i),
      .src_ready_o(src_ready_o),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .busy_o     (busy_o),
      .grant_o    (grant_o),
      .drop_cnt_o (drop_cnt_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   int          checks = 0;
   int          failures = 0;
   logic [32:0] exp_q[$];      // {is_header, word}
   int          cyc = 0;
   bit          tp_on = 1'b0;
   int          last_hdr_cyc = -1;
   logic        stalled = 1'b0;
   logic [31:0] stall_data = '0;
   logic [32:0] mon_e;

   always @(posedge sys_clk_i) cyc = cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every accepted word and checks stability under stall.
   always @(negedge sys_clk_i) begin
      if (rstn_i && valid_o) begin
         if (stalled) check("stable_under_stall", 64'(data_o), 64'(stall_data));
         if (ready_i) begin
            if (exp_q.size() == 0) begin
               checks   = checks + 1;
               failures = failures + 1;
               $display("FAIL unexpected_word: got %h expected none", data_o);
            end else begin
               mon_e = exp_q.pop_front();
               check("word", 64'(data_o), 64'(mon_e[31:0]));
               if (mon_e[32] && tp_on) begin
                  if (last_hdr_cyc >= 0) check("record_period", 64'(cyc - last_hdr_cyc), 64'd5);
                  last_hdr_cyc = cyc;
               end
            end
            stalled = 1'b0;
         end else begin
            stalled    = 1'b1;
            stall_data = data_o;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic tick();
      @(posedge sys_clk_i);
      #1;
   endtask

   task automatic push_hdr(input int src, input int seq);
      exp_q.push_back({1'b1, 4'hA, 2'b00, 2'(src), 20'h0, 4'(seq)});
   endtask

   task automatic push_rec(input int src, input int seq, input logic [95:0] d);
      push_hdr(src, seq);
      exp_q.push_back({1'b0, d[95:64]});
      exp_q.push_back({1'b0, d[63:32]});
      exp_q.push_back({1'b0, d[31:0]});
   endtask

   task automatic send(input int src, input logic [95:0] d);
      bit ok;
      ok = 1'b0;
      src_data_i[src*96 +: 96] = d;
      src_valid_i[src] = 1'b1;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge sys_clk_i);
         if (src_ready_o[src]) ok = 1'b1;
         @(posedge sys_clk_i);
         #1;
      end
      src_valid_i[src] = 1'b0;
      check("send_accepted", 64'(ok), 64'd1);
   endtask

   task automatic wait_drain(input bit rand_ready);
      for (int k = 0; k < 3000 && (exp_q.size() != 0 || busy_o); k++) begin
         if (rand_ready) ready_i = 1'($urandom_range(0, 1));
         tick();
      end
      ready_i = 1'b1;
      check("drain", 64'(exp_q.size() == 0 && !busy_o), 64'd1);
   endtask

   task automatic pulse_clr();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
   endtask

   task automatic contention();
      logic [95:0] d [2][2];
      int          n [2];
      logic [1:0]  acc;
      d[0][0] = 96'hA0A0_0000_A0A0_0001_A0A0_0002;
      d[0][1] = 96'hA1A1_0000_A1A1_0001_A1A1_0002;
      d[1][0] = 96'hB0B0_0000_B0B0_0001_B0B0_0002;
      d[1][1] = 96'hB1B1_0000_B1B1_0001_B1B1_0002;
      push_rec(0, 0, d[0][0]);
      push_rec(1, 0, d[1][0]);
      push_rec(0, 1, d[0][1]);
      push_rec(1, 1, d[1][1]);
      n[0] = 0;
      n[1] = 0;
      src_data_i[0 +: 96]  = d[0][0];
      src_data_i[96 +: 96] = d[1][0];
      src_valid_i = 2'b11;
      for (int k = 0; k < 200 && (n[0] < 2 || n[1] < 2); k++) begin
         @(negedge sys_clk_i);
         acc = src_valid_i & src_ready_o;
         if (acc == 2'b11) check("one_grant_per_capture", 64'(acc), 64'd1);
         @(posedge sys_clk_i);
         #1;
         for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
               n[s] = n[s] + 1;
               if (n[s] == 2) src_valid_i[s] = 1'b0;
               else           src_data_i[s*96 +: 96] = d[s][1];
            end
         end
      end
      check("contention_accepts", 64'(n[0] == 2 && n[1] == 2), 64'd1);
   endtask

   initial begin
      // ---------------- reset state ----------------
      en_i = 1'b1;
      ready_i = 1'b1;
      src_valid_i = 2'b01;
      repeat (3) tick();
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_data", 64'(data_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_grant", 64'(grant_o), 64'd0);
      check("rst_ready", 64'(src_ready_o), 64'd0);
      check("rst_drop", 64'(drop_cnt_o), 64'd0);
      src_valid_i = '0;
      rstn_i = 1'b1;
      tick();

      // ---------------- single source + throughput ----------------
      tp_on = 1'b1;
      last_hdr_cyc = -1;
      push_rec(0, 0, 96'h1111_2222_3333_4444_5555_6666);
      push_rec(0, 1, 96'h7777_8888_9999_AAAA_BBBB_CCCC);
      send(0, 96'h1111_2222_3333_4444_5555_6666);
      send(0, 96'h7777_8888_9999_AAAA_BBBB_CCCC);
      wait_drain(1'b0);

      // ---------------- contention 0,1,0,1 ----------------
      pulse_clr();
      last_hdr_cyc = -1;
      contention();
      wait_drain(1'b0);
      tp_on = 1'b0;
      check("grant_after_contention", 64'(grant_o), 64'd1);

      // ---------------- random backpressure ----------------
      ready_i = 1'b0;
      push_rec(0, 2, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
      send(0, 96'hDEAD_BEEF_0123_4567_89AB_CDEF);
      wait_drain(1'b1);
      ready_i = 1'b0;
      push_rec(1, 2, 96'hFEDC_BA98_7654_3210_CAFE_F00D);
      send(1, 96'hFEDC_BA98_7654_3210_CAFE_F00D);
      wait_drain(1'b1);

      // ---------------- disabled: drops ----------------
      pulse_clr();
      en_i = 1'b0;
      for (int k = 0; k < 3; k++) send(1, 96'(k));
      tick();
      check("drop1_after_3", 64'(drop_cnt_o[15:8]), 64'd3);
      check("drop0_untouched", 64'(drop_cnt_o[7:0]), 64'd0);
      en_i = 1'b1;
      push_rec(1, 0, 96'h0101_0202_0303_0404_0505_0606);
      send(1, 96'h0101_0202_0303_0404_0505_0606);
      wait_drain(1'b0);
      check("drop1_kept", 64'(drop_cnt_o[15:8]), 64'd3);

      // ---------------- drop saturation ----------------
      pulse_clr();
      en_i = 1'b0;
      src_valid_i[0] = 1'b1;
      repeat (255) tick();
      check("drop0_at_max", 64'(drop_cnt_o[7:0]), 64'hFF);
      repeat (3) tick();
      src_valid_i[0] = 1'b0;
      check("drop0_saturated", 64'(drop_cnt_o[7:0]), 64'hFF);
      check("drop1_zero", 64'(drop_cnt_o[15:8]), 64'd0);
      en_i = 1'b1;

      // ---------------- sequence wrap: 2^SEQ_W + 1 records ----------------
      pulse_clr();
      for (int r = 0; r <= (1 << SEQ_W); r++) begin
         push_rec(0, r, {8'h50, 24'(r), 8'h60, 24'(r), 8'h70, 24'(r)});
         send(0, {8'h50, 24'(r), 8'h60, 24'(r), 8'h70, 24'(r)});
      end
      wait_drain(1'b0);

      // ---------------- clear mid-record (in W_HI) ----------------
      pulse_clr();
      ready_i = 1'b0;
      push_hdr(0, 0);
      send(0, 96'h9999_0000_8888_0000_7777_0000);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check("busy_in_w_hi", 64'(busy_o), 64'd1);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      check("clr_valid", 64'(valid_o), 64'd0);
      check("clr_busy", 64'(busy_o), 64'd0);
      check("clr_grant", 64'(grant_o), 64'd0);
      check("clr_drop", 64'(drop_cnt_o), 64'd0);
      src_valid_i[0] = 1'b1;
      clr_i = 1'b1;
      @(negedge sys_clk_i);
      check("clr_blocks_ready", 64'(src_ready_o), 64'd0);
      tick();
      clr_i = 1'b0;
      src_valid_i[0] = 1'b0;
      check("clr_no_capture", 64'(busy_o), 64'd0);
      ready_i = 1'b1;
      push_rec(0, 0, 96'h1234_5678_9ABC_DEF0_0FED_CBA9);
      send(0, 96'h1234_5678_9ABC_DEF0_0FED_CBA9);
      wait_drain(1'b0);

      // ---------------- reset mid-record (in W_MID) ----------------
      push_hdr(1, 0);
      exp_q.push_back({1'b0, 32'h4444_AAAA});
      send(1, 96'h4444_AAAA_5555_BBBB_6666_CCCC);
      tick();
      tick();
      ready_i = 1'b0;
      check("busy_in_w_mid", 64'(busy_o), 64'd1);
      src_valid_i[0] = 1'b1;
      rstn_i = 1'b0;
      #1;
      check("arst_valid", 64'(valid_o), 64'd0);
      check("arst_data", 64'(data_o), 64'd0);
      check("arst_busy", 64'(busy_o), 64'd0);
      check("arst_grant", 64'(grant_o), 64'd0);
      check("arst_ready", 64'(src_ready_o), 64'd0);
      check("arst_sb_empty", 64'(exp_q.size()), 64'd0);
      tick();
      src_valid_i = '0;
      rstn_i = 1'b1;
      ready_i = 1'b1;
      tick();
      push_rec(0, 0, 96'hAAAA_0001_BBBB_0002_CCCC_0003);
      send(0, 96'hAAAA_0001_BBBB_0002_CCCC_0003);
      wait_drain(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
